// File: rtl/ice40_master_spi_controller.sv
// Purpose : SPI-master front end for the iCE40UP5K SB_SPI hard IP; programs it once, then sends single bytes.
// Latency : first bus strobe 1 cycle after tx_start is accepted; each bus access lasts until SBACKO returns.
// Backpres: tx_busy high while initialising/transmitting; tx_start ignored (not queued) whenever not IDLE.
//
// Ports
//   clk, reset         : system clock (rising edge), asynchronous active-low reset
//   tx_start, tx_data  : user request level and byte (byte latched on the accepting edge)
//   tx_busy            : high while the init sequence or a transfer is in progress
//   spi_rw/_reg_addr/_strobe/_data_in : SB_SPI SBRWI / SBADRI / SBSTBI / SBDATI
//   spi_data_out, spi_ack             : SB_SPI SBDATO / SBACKO
//   b, g, r            : active-low debug LEDs, present only when ICE40_SPI_DEBUG_EN is defined
//                        (r = init, g = idle, b = transfer)
module ice40_master_spi_controller #(
  parameter int SPI_CLK_DIVIDER = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [7:0] spi_data_out,
  input  logic       spi_ack,
  output logic       spi_rw,
  output logic [7:0] spi_reg_addr,
  output logic       spi_strobe,
  output logic [7:0] spi_data_in,
  output logic       tx_busy
`ifdef ICE40_SPI_DEBUG_EN
  ,
  output logic       b,
  output logic       g,
  output logic       r
`endif
);

  // SB_SPI register map (SPI instance at base 0000)
  localparam logic [7:0] ADDR_CR0  = 8'h08;
  localparam logic [7:0] ADDR_CR1  = 8'h09;
  localparam logic [7:0] ADDR_CR2  = 8'h0A;
  localparam logic [7:0] ADDR_BR   = 8'h0B;
  localparam logic [7:0] ADDR_SR   = 8'h0C;
  localparam logic [7:0] ADDR_TXDR = 8'h0D;
  localparam logic [7:0] ADDR_RXDR = 8'h0E;
  localparam logic [7:0] ADDR_CSR  = 8'h0F;
  localparam int         SR_TRDY   = 4;

  // Only the low six bits of the divider reach SPIBR.
  localparam logic [31:0] DIV_VEC = SPI_CLK_DIVIDER;
  localparam logic [7:0]  BR_VAL  = {2'b00, DIV_VEC[5:0]};

  typedef enum logic [3:0] {
    S_INIT_CR0,
    S_INIT_CR1,
    S_INIT_CR2,
    S_INIT_BR,
    S_INIT_CSR,
    S_IDLE,
    S_POLL_TRDY,
    S_WRITE_TX,
    S_WAIT_DONE
  } state_t;

  state_t     state_q, state_nxt;
  logic       strobe_q, strobe_nxt;
  logic       rw_q, rw_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] wdat_q, wdat_nxt;
  logic       busy_q, busy_nxt;
  logic [7:0] tx_byte_q, tx_byte_nxt;
  logic [7:0] rd_q, rd_nxt;

  // Bus access described by the current state: what to drive, and where to
  // go once the slave acknowledges it.
  logic       acc_en;
  logic       acc_rw;
  logic [7:0] acc_addr;
  logic [7:0] acc_dat;
  state_t     acc_next;
  logic       trdy;

  assign trdy = spi_data_out[SR_TRDY];

  always_comb begin
    acc_en   = 1'b1;
    acc_rw   = 1'b1;
    acc_addr = 8'h00;
    acc_dat  = 8'h00;
    acc_next = state_q;
    case (state_q)
      S_INIT_CR0: begin
        acc_addr = ADDR_CR0;
        acc_dat  = 8'h00;
        acc_next = S_INIT_CR1;
      end
      S_INIT_CR1: begin
        acc_addr = ADDR_CR1;
        acc_dat  = 8'h80;          // SPI enable
        acc_next = S_INIT_CR2;
      end
      S_INIT_CR2: begin
        acc_addr = ADDR_CR2;
        acc_dat  = 8'h80;          // master mode
        acc_next = S_INIT_BR;
      end
      S_INIT_BR: begin
        acc_addr = ADDR_BR;
        acc_dat  = BR_VAL;
        acc_next = S_INIT_CSR;
      end
      S_INIT_CSR: begin
        acc_addr = ADDR_CSR;
        acc_dat  = 8'h01;
        acc_next = S_IDLE;
      end
      S_POLL_TRDY: begin
        acc_rw   = 1'b0;
        acc_addr = ADDR_SR;
        acc_next = trdy ? S_WRITE_TX : S_POLL_TRDY;
      end
      S_WRITE_TX: begin
        acc_addr = ADDR_TXDR;
        acc_dat  = tx_byte_q;
        acc_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        acc_rw   = 1'b0;
        acc_addr = ADDR_SR;
        acc_next = trdy ? S_IDLE : S_WAIT_DONE;
      end
      S_IDLE: begin
        acc_en   = 1'b0;
      end
      default: begin
        acc_en   = 1'b0;
        acc_next = S_INIT_CR0;
      end
    endcase
  end

  // Next-state / output logic. Every access starts from strobe low: the cycle
  // after an ack always has strobe low, which gives the mandatory gap, and a
  // retried SR read re-raises strobe on the following edge.
  always_comb begin
    state_nxt   = state_q;
    strobe_nxt  = strobe_q;
    rw_nxt      = rw_q;
    addr_nxt    = addr_q;
    wdat_nxt    = wdat_q;
    busy_nxt    = busy_q;
    tx_byte_nxt = tx_byte_q;
    rd_nxt      = rd_q;

    if (state_q == S_IDLE) begin
      busy_nxt = 1'b0;
      if (tx_start) begin
        tx_byte_nxt = tx_data;
        busy_nxt    = 1'b1;
        state_nxt   = S_POLL_TRDY;
      end
    end else if (acc_en) begin
      if (!strobe_q) begin
        strobe_nxt = 1'b1;
        rw_nxt     = acc_rw;
        addr_nxt   = acc_addr;
        wdat_nxt   = acc_rw ? acc_dat : 8'h00;
      end else if (spi_ack) begin
        // ack only counts while strobe is high; address/data were held until now
        strobe_nxt = 1'b0;
        if (!rw_q) begin
          rd_nxt = spi_data_out;
        end
        state_nxt = acc_next;
        if (acc_next == S_IDLE) begin
          busy_nxt = 1'b0;
        end
      end
    end else begin
      strobe_nxt = 1'b0;
      busy_nxt   = 1'b1;
      state_nxt  = S_INIT_CR0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT_CR0;
      strobe_q  <= 1'b0;
      rw_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdat_q    <= 8'h00;
      busy_q    <= 1'b1;
      tx_byte_q <= 8'h00;
      rd_q      <= 8'h00;
    end else begin
      state_q   <= state_nxt;
      strobe_q  <= strobe_nxt;
      rw_q      <= rw_nxt;
      addr_q    <= addr_nxt;
      wdat_q    <= wdat_nxt;
      busy_q    <= busy_nxt;
      tx_byte_q <= tx_byte_nxt;
      rd_q      <= rd_nxt;
    end
  end

  assign spi_strobe   = strobe_q;
  assign spi_rw       = rw_q;
  assign spi_reg_addr = addr_q;
  assign spi_data_in  = wdat_q;
  assign tx_busy      = busy_q;

  // Last read value is kept for observability only; RXDR is never read since
  // this controller is transmit-only.
  logic       unused_rd;
  logic [7:0] unused_rxdr_addr;
  assign unused_rd        = ^rd_q;
  assign unused_rxdr_addr = ADDR_RXDR;

`ifdef ICE40_SPI_DEBUG_EN
  // LEDs follow the state being entered so they line up with state_q.
  logic led_r_q, led_g_q, led_b_q;
  logic nxt_init, nxt_idle;

  assign nxt_init = (state_nxt == S_INIT_CR0) || (state_nxt == S_INIT_CR1) ||
                    (state_nxt == S_INIT_CR2) || (state_nxt == S_INIT_BR)  ||
                    (state_nxt == S_INIT_CSR);
  assign nxt_idle = (state_nxt == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_r_q <= 1'b1;
      led_g_q <= 1'b1;
      led_b_q <= 1'b1;
    end else begin
      led_r_q <= ~nxt_init;
      led_g_q <= ~nxt_idle;
      led_b_q <= nxt_init | nxt_idle;
    end
  end

  assign r = led_r_q;
  assign g = led_g_q;
  assign b = led_b_q;
`endif

endmodule

// File: tb/tb_ice40_master_spi_controller.sv
module tb_ice40_master_spi_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] spi_data_out;
  logic       spi_ack;
  logic       spi_rw;
  logic [7:0] spi_reg_addr;
  logic       spi_strobe;
  logic [7:0] spi_data_in;
  logic       tx_busy;

  int total = 0;
  int bad   = 0;

  ice40_master_spi_controller #(.SPI_CLK_DIVIDER(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .spi_data_out (spi_data_out),
    .spi_ack      (spi_ack),
    .spi_rw       (spi_rw),
    .spi_reg_addr (spi_reg_addr),
    .spi_strobe   (spi_strobe),
    .spi_data_in  (spi_data_in),
    .tx_busy      (tx_busy)
  );

  always #5 clk = ~clk;

  // Slave mock: acks on the 3rd low phase after strobe rises. Each access is
  // logged as {tx_busy, rw, addr, data} when strobe is first seen high.
  logic [17:0] txq[$];
  logic [16:0] held;
  int          cnt      = 0;
  int          sr_zero  = 0;
  int          unstable = 0;

  always @(negedge clk) begin
    if (!spi_strobe) begin
      cnt     = 0;
      spi_ack = 1'b0;
    end else begin
      if (cnt == 0) begin
        held = {spi_rw, spi_reg_addr, spi_data_in};
        txq.push_back({tx_busy, spi_rw, spi_reg_addr, spi_data_in});
      end else if (held !== {spi_rw, spi_reg_addr, spi_data_in}) begin
        unstable++;
      end
      cnt++;
      if (cnt == 3) begin
        spi_ack      = 1'b1;
        spi_data_out = 8'h00;
        if (!spi_rw && spi_reg_addr == 8'h0C) begin
          if (sr_zero > 0) sr_zero--;
          else spi_data_out = 8'h10;
        end
      end else begin
        spi_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic get_txn(input string tag, output logic [17:0] t);
    int n = 0;
    t = '0;
    while (txq.size() == 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (txq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: observed=no bus access expected=bus access within 300 cycles", tag);
    end else begin
      t = txq.pop_front();
    end
  endtask

  // Check rw/addr (and data for writes) of the next bus access.
  task automatic exp_txn(input string tag, input logic rw, input logic [7:0] addr,
                         input logic [7:0] dat);
    logic [17:0] t;
    get_txn(tag, t);
    chk({tag, "_rw"},   {31'd0, t[16]}, {31'd0, rw});
    chk({tag, "_addr"}, {24'd0, t[15:8]}, {24'd0, addr});
    if (rw) chk({tag, "_data"}, {24'd0, t[7:0]}, {24'd0, dat});
    chk({tag, "_busy"}, {31'd0, t[17]}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (tx_busy !== 1'b0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk); #1;
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic exp_init(input string tag);
    exp_txn({tag, "_cr1"}, 1'b1, 8'h09, 8'h80);
    exp_txn({tag, "_cr2"}, 1'b1, 8'h0A, 8'h80);
    exp_txn({tag, "_br"},  1'b1, 8'h0B, 8'h01);
    exp_txn({tag, "_csr"}, 1'b1, 8'h0F, 8'h01);
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    reset        = 1'b0;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    spi_ack      = 1'b0;
    spi_data_out = 8'h00;

    // reset state
    @(negedge clk); #1;
    chk("rst_busy",   {31'd0, tx_busy},    32'd1);
    chk("rst_strobe", {31'd0, spi_strobe}, 32'd0);
    chk("rst_rw",     {31'd0, spi_rw},     32'd0);
    chk("rst_addr",   {24'd0, spi_reg_addr}, 32'd0);
    chk("rst_wdat",   {24'd0, spi_data_in},  32'd0);
    reset = 1'b1;

    // init sequence; tx_start pulsed during it must be dropped
    exp_txn("init_cr0", 1'b1, 8'h08, 8'h00);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    @(negedge clk); #1;
    tx_start = 1'b0;
    exp_init("init");
    repeat (20) @(negedge clk);
    #1;
    chk("init_start_ignored", txq.size(), 32'd0);
    chk("init_still_idle", {31'd0, tx_busy}, 32'd0);

    // single byte, TRDY ready at once; tx_data changes after acceptance
    pulse_start(8'hAA);
    chk("tx1_busy_on_accept", {31'd0, tx_busy}, 32'd1);
    tx_data = 8'h33;
    exp_txn("tx1_poll", 1'b0, 8'h0C, 8'h00);
    exp_txn("tx1_txdr", 1'b1, 8'h0D, 8'hAA);
    exp_txn("tx1_done", 1'b0, 8'h0C, 8'h00);
    wait_idle("tx1_idle");

    // TRDY low three times before the write goes out
    sr_zero = 3;
    pulse_start(8'h5A);
    for (int i = 0; i < 4; i++) exp_txn("tx2_poll", 1'b0, 8'h0C, 8'h00);
    exp_txn("tx2_txdr", 1'b1, 8'h0D, 8'h5A);
    exp_txn("tx2_done", 1'b0, 8'h0C, 8'h00);
    wait_idle("tx2_idle");

    // tx_start held high: back-to-back transfers, each re-latching tx_data
    @(negedge clk); #1;
    tx_data  = 8'h11;
    tx_start = 1'b1;
    exp_txn("b2b_poll0", 1'b0, 8'h0C, 8'h00);
    exp_txn("b2b_txdr0", 1'b1, 8'h0D, 8'h11);
    tx_data = 8'h22;
    exp_txn("b2b_done0", 1'b0, 8'h0C, 8'h00);
    exp_txn("b2b_poll1", 1'b0, 8'h0C, 8'h00);
    exp_txn("b2b_txdr1", 1'b1, 8'h0D, 8'h22);
    tx_start = 1'b0;
    exp_txn("b2b_done1", 1'b0, 8'h0C, 8'h00);
    wait_idle("b2b_idle");
    repeat (20) @(negedge clk);
    #1;
    chk("b2b_no_extra", txq.size(), 32'd0);

    // reset while strobe is high in POLL_TRDY
    sr_zero = 100;
    pulse_start(8'hC3);
    exp_txn("rst_poll", 1'b0, 8'h0C, 8'h00);
    chk("rst_poll_strobe_hi", {31'd0, spi_strobe}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_strobe", {31'd0, spi_strobe}, 32'd0);
    chk("midrst_busy",   {31'd0, tx_busy},    32'd1);
    @(negedge clk); #1;
    sr_zero = 0;
    txq.delete();
    reset = 1'b1;
    exp_txn("reinit_cr0", 1'b1, 8'h08, 8'h00);
    exp_init("reinit");

    chk("bus_stable", unstable, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
